// File: rtl/csr_pkg.sv
// Shared CSR types and constants for the encoder and the SpGEMM datapath.
package csr_pkg;

    localparam int unsigned CSR_LANES  = 16;
    localparam int unsigned CSR_LANE_W = 32;
    localparam int unsigned CSR_IDX_W  = 4;

    // Lane 0 sits at the MSBs of the flattened 512-bit bus.
    typedef logic [0:CSR_LANES-1][CSR_LANE_W-1:0] csr_arr_t;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } csr_state_e;

endpackage

// File: rtl/dense_to_csr_enc_if.sv
// Dense element stream: row-major values with a valid/ready handshake.
interface dense_to_csr_enc_if;

    logic                              valid;
    logic [csr_pkg::CSR_LANE_W-1:0]    data;
    logic                              ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/csr_lane_wr.sv
// Packed 16-lane register with synchronous clear and a single indexed write port.
module csr_lane_wr
    import csr_pkg::*;
(
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            clr_i,
    input  logic                            we_i,
    input  logic [CSR_IDX_W-1:0]            idx_i,
    input  logic [CSR_LANE_W-1:0]           data_i,
    output logic [CSR_LANES*CSR_LANE_W-1:0] flat_o
);

    csr_arr_t arr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            arr_q <= '0;
        end else if (clr_i) begin
            arr_q <= '0;
        end else if (we_i) begin
            arr_q[idx_i] <= data_i;
        end
    end

    assign flat_o = arr_q;

endmodule

// File: rtl/dense_to_csr_enc.sv
// Dense-to-CSR encoder: consumes a row-major element stream and builds NV/CI/RP lane arrays.
module dense_to_csr_enc
    import csr_pkg::*;
#(
    parameter int unsigned LANES  = CSR_LANES,
    parameter int unsigned LANE_W = CSR_LANE_W
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [3:0]              rows_i,
    input  logic [4:0]              cols_i,
    dense_to_csr_enc_if.slave       elem,
    output logic [LANES*LANE_W-1:0] NV_o,
    output logic [LANES*LANE_W-1:0] CI_o,
    output logic [LANES*LANE_W-1:0] RP_o,
    output logic [4:0]              nnz_o,
    output logic                    computing_o,
    output logic                    op_complete_o,
    output logic                    overflow_o
);

    csr_state_e state_q;
    logic [3:0] rows_q, row_q;
    logic [4:0] cols_q, col_q;
    logic [4:0] nnz_q;
    logic       ovf_q, done_q, busy_q;

    logic       beat, nonzero, room, store, row_end, last_beat;
    logic [4:0] nnz_nxt;

    assign elem.ready = (state_q == StScan);

    // A start in the same cycle as a handshake discards the beat.
    assign beat      = elem.valid && elem.ready && !start_i;
    assign nonzero   = (elem.data != '0);
    assign room      = (nnz_q < 5'd16);
    assign store     = beat && nonzero && room;
    assign nnz_nxt   = nnz_q + {4'd0, store};
    assign row_end   = (col_q == cols_q - 5'd1);
    assign last_beat = row_end && (row_q == rows_q - 4'd1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            rows_q  <= '0;
            cols_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            nnz_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else if (start_i) begin
            rows_q <= rows_i;
            cols_q <= cols_i;
            row_q  <= '0;
            col_q  <= '0;
            nnz_q  <= '0;
            ovf_q  <= 1'b0;
            if (rows_i == 4'd0 || cols_i == 5'd0) begin
                state_q <= StDone;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
            end else begin
                state_q <= StScan;
                done_q  <= 1'b0;
                busy_q  <= 1'b1;
            end
        end else if (beat) begin
            nnz_q <= nnz_nxt;
            if (nonzero && !room) begin
                ovf_q <= 1'b1;
            end
            if (row_end) begin
                col_q <= '0;
                row_q <= row_q + 4'd1;
                if (last_beat) begin
                    state_q <= StDone;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
            end else begin
                col_q <= col_q + 5'd1;
            end
        end
    end

    csr_lane_wr u_nv (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (start_i),
        .we_i   (store),
        .idx_i  (nnz_q[3:0]),
        .data_i (elem.data),
        .flat_o (NV_o)
    );

    csr_lane_wr u_ci (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (start_i),
        .we_i   (store),
        .idx_i  (nnz_q[3:0]),
        .data_i ({{(LANE_W-5){1'b0}}, col_q}),
        .flat_o (CI_o)
    );

    // RP[0] is never written; nnz already saturates at 16, so RP does too.
    csr_lane_wr u_rp (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (start_i),
        .we_i   (beat && row_end),
        .idx_i  (row_q + 4'd1),
        .data_i ({{(LANE_W-5){1'b0}}, nnz_nxt}),
        .flat_o (RP_o)
    );

    assign nnz_o         = nnz_q;
    assign computing_o   = busy_q;
    assign op_complete_o = done_q;
    assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_dense_to_csr_enc.sv
// Randomised and directed bench for dense_to_csr_enc against a matrix-level CSR model.
module tb_dense_to_csr_enc;
    import csr_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         start_i;
    logic [3:0]   rows_i;
    logic [4:0]   cols_i;
    logic [511:0] NV_o, CI_o, RP_o;
    logic [4:0]   nnz_o;
    logic         computing_o, op_complete_o, overflow_o;

    dense_to_csr_enc_if elem_if ();

    dense_to_csr_enc dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .rows_i        (rows_i),
        .cols_i        (cols_i),
        .elem          (elem_if),
        .NV_o          (NV_o),
        .CI_o          (CI_o),
        .RP_o          (RP_o),
        .nnz_o         (nnz_o),
        .computing_o   (computing_o),
        .op_complete_o (op_complete_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned  n_checks = 0;
    int unsigned  n_errors = 0;
    logic [31:0]  mat [0:255];
    int unsigned  vals [$];

    task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: walk the matrix, keep the first 16 non-zeros, row pointers clamp at 16.
    task automatic model(input int r, input int c, output csr_arr_t nv, output csr_arr_t ci,
                         output csr_arr_t rp, output int nnz, output logic ovf);
        int total = 0;
        nv = '0;
        ci = '0;
        rp = '0;
        for (int i = 0; i < r; i++) begin
            for (int j = 0; j < c; j++) begin
                if (mat[i*c+j] != 0) begin
                    if (total < 16) begin
                        nv[total] = mat[i*c+j];
                        ci[total] = j;
                    end
                    total++;
                end
            end
            rp[i+1] = (total > 16) ? 16 : total;
        end
        nnz = (total > 16) ? 16 : total;
        ovf = (total > 16);
    endtask

    task automatic load(input int n);
        for (int i = 0; i < 256; i++) mat[i] = (i < n) ? vals[i] : 32'd0;
    endtask

    // mode: 0 = no stalls, 1 = valid low on every other cycle, 2 = random stalls
    task automatic run_case(input string tag, input int r, input int c, input int mode);
        csr_arr_t    nv, ci, rp;
        int          nnz;
        logic        ovf;
        int          idx = 0;
        int          cycles = 0;
        int          stalls = 0;
        logic        drive;
        logic [511:0] nv_keep;
        model(r, c, nv, ci, rp, nnz, ovf);
        start_i       = 1'b1;
        rows_i        = r[3:0];
        cols_i        = c[4:0];
        elem_if.valid = 1'b1;
        elem_if.data  = 32'hBAD0_0001;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        cycles  = 1;
        check_val({tag, ":computing"}, computing_o, (r != 0 && c != 0));
        while (!op_complete_o && cycles < 2000) begin
            case (mode)
                0:       drive = 1'b1;
                1:       drive = (cycles % 2 == 0);
                default: drive = ($urandom_range(0, 3) != 0);
            endcase
            elem_if.valid = drive;
            elem_if.data  = (drive && idx < 256) ? mat[idx] : $urandom;
            if (!drive) stalls++;
            @(posedge clk_i); #1;
            cycles++;
            if (drive) idx++;
        end
        elem_if.valid = 1'b0;
        check_val({tag, ":latency"}, cycles, 1 + r*c + stalls);
        check_val({tag, ":done"}, op_complete_o, 1'b1);
        check_val({tag, ":busy_off"}, computing_o, 1'b0);
        check_val({tag, ":ready_off"}, elem_if.ready, 1'b0);
        check_val({tag, ":NV"}, NV_o, nv);
        check_val({tag, ":CI"}, CI_o, ci);
        check_val({tag, ":RP"}, RP_o, rp);
        check_val({tag, ":nnz"}, nnz_o, nnz);
        check_val({tag, ":ovf"}, overflow_o, ovf);
        // Beats offered while done must be ignored.
        nv_keep       = nv;
        elem_if.valid = 1'b1;
        elem_if.data  = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk_i);
        #1;
        elem_if.valid = 1'b0;
        check_val({tag, ":hold_NV"}, NV_o, nv_keep);
        check_val({tag, ":hold_done"}, op_complete_o, 1'b1);
    endtask

    initial begin
        rst_i         = 1'b1;
        start_i       = 1'b0;
        rows_i        = '0;
        cols_i        = '0;
        elem_if.valid = 1'b0;
        elem_if.data  = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check_val("reset:outs", {NV_o, CI_o, RP_o}, '0);
        check_val("reset:flags", {nnz_o, computing_o, op_complete_o, overflow_o, elem_if.ready}, '0);

        vals = '{5, 0, 0, 0, 7, 0, 0, 0, 9};
        load(9);
        run_case("ident", 3, 3, 0);
        check_val("ident:nnz3", nnz_o, 5'd3);

        vals = '{0, 3, 0, 4, 0, 0, 0, 0};
        load(8);
        run_case("row_a", 2, 4, 0);
        vals = '{1, 0, 0, 0, 0, 2};
        load(6);
        run_case("row_b", 3, 2, 0);

        vals = '{5, 0, 0, 0, 7, 0, 0, 0, 9};
        load(9);
        run_case("bp", 3, 3, 1);

        vals = {};
        for (int i = 0; i < 18; i++) vals.push_back(1);
        load(18);
        run_case("ovf", 3, 6, 0);

        run_case("rows0", 0, 5, 0);
        run_case("cols0", 4, 0, 0);

        vals = {};
        for (int i = 0; i < 16; i++) vals.push_back(i + 1);
        load(16);
        run_case("full", 1, 16, 0);

        // Restart in the middle of a scan with a live beat on the start edge.
        start_i = 1'b1;
        rows_i  = 4'd4;
        cols_i  = 5'd4;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        elem_if.valid = 1'b1;
        elem_if.data  = 32'h0000_0042;
        repeat (3) @(posedge clk_i);
        #1;
        vals = '{0, 0, 6, 8};
        load(4);
        run_case("restart", 2, 2, 0);

        // Asynchronous reset mid-encode, asserted between clock edges.
        start_i = 1'b1;
        rows_i  = 4'd4;
        cols_i  = 5'd4;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        elem_if.valid = 1'b1;
        elem_if.data  = 32'h0000_0011;
        repeat (4) @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        check_val("arst:outs", {NV_o, CI_o, RP_o}, '0);
        check_val("arst:flags", {nnz_o, computing_o, op_complete_o, overflow_o, elem_if.ready}, '0);
        elem_if.valid = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        for (int t = 0; t < 20; t++) begin
            int r = $urandom_range(0, 15);
            int c = $urandom_range(0, 16);
            for (int i = 0; i < 256; i++) mat[i] = ($urandom_range(0, 2) == 0) ? $urandom : 32'd0;
            run_case($sformatf("rnd%0d", t), r, c, 2);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
